// File: rtl/ahb_pkg.sv
// AHB protocol encodings and bridge state type shared by the AHB/Wishbone bridges.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StAddr,
        StData
    } bridge_state_e;

endpackage

// File: rtl/wb2ahb.sv
// Wishbone-slave to AHB-master bridge: one NONSEQ SINGLE transfer per classic Wishbone cycle.
// Define WB2AHB_RETRY_EN to re-issue transfers on RETRY/SPLIT; otherwise they end as errors.
module wb2ahb
    import ahb_pkg::*;
#(
    parameter int unsigned AWIDTH      = 16,
    parameter int unsigned DWIDTH      = 32,
    parameter logic [2:0]  HSIZE_VAL   = HSIZE_WORD,
    parameter int unsigned RETRY_LIMIT = 15
) (
    input  logic              hclk,
    input  logic              hresetn,
    // Wishbone slave
    input  logic [AWIDTH-1:0] adr_i,
    input  logic [DWIDTH-1:0] dat_i,
    output logic [DWIDTH-1:0] dat_o,
    input  logic              we_i,
    input  logic              cyc_i,
    input  logic              stb_i,
    output logic              ack_o,
    output logic              err_o,
    // AHB master
    output logic              hbusreq,
    input  logic              hgrant,
    output logic [AWIDTH-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [DWIDTH-1:0] hwdata,
    input  logic [DWIDTH-1:0] hrdata,
    input  logic              hready,
    input  logic [1:0]        hresp
);

`ifdef WB2AHB_RETRY_EN
    localparam int unsigned RetryCntW = (RETRY_LIMIT < 2) ? 1 : $clog2(RETRY_LIMIT + 1);
    logic [RetryCntW-1:0] retry_cnt;
`endif

    bridge_state_e     state;
    logic [AWIDTH-1:0] adr_q;
    logic [DWIDTH-1:0] dat_q;
    logic              we_q;
    logic              wb_start;
    logic              wb_live;

    assign hsize  = HSIZE_VAL;
    assign hburst = HBURST_SINGLE;

    // The ack/err guard keeps a master still strobing on the response cycle from re-triggering.
    assign wb_start = cyc_i && stb_i && !ack_o && !err_o;
    assign wb_live  = cyc_i && stb_i;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state   <= StIdle;
            adr_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            hbusreq <= 1'b0;
            haddr   <= '0;
            htrans  <= HTRANS_IDLE;
            hwrite  <= 1'b0;
            hwdata  <= '0;
            dat_o   <= '0;
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
`ifdef WB2AHB_RETRY_EN
            retry_cnt <= '0;
`endif
        end else begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (wb_start) begin
                        adr_q   <= adr_i;
                        we_q    <= we_i;
                        dat_q   <= dat_i;
                        hbusreq <= 1'b1;
                        state   <= StReq;
`ifdef WB2AHB_RETRY_EN
                        retry_cnt <= '0;
`endif
                    end
                end
                StReq: begin
                    if (hgrant && hready) begin
                        htrans  <= HTRANS_NONSEQ;
                        haddr   <= adr_q;
                        hwrite  <= we_q;
                        hbusreq <= 1'b0;
                        state   <= StAddr;
                    end
                end
                StAddr: begin
                    if (hready) begin
                        htrans <= HTRANS_IDLE;
                        if (we_q) begin
                            hwdata <= dat_q;
                        end
                        state <= StData;
                    end
                end
                StData: begin
                    // Two-cycle error responses simply wait here until hready rises.
                    if (hready) begin
                        state <= StIdle;
                        case (hresp)
                            HRESP_OKAY: begin
                                if (!we_q && wb_live) begin
                                    dat_o <= hrdata;
                                end
                                ack_o <= wb_live;
                            end
                            HRESP_ERROR: begin
                                err_o <= wb_live;
                            end
                            default: begin
`ifdef WB2AHB_RETRY_EN
                                if (retry_cnt == RetryCntW'(RETRY_LIMIT)) begin
                                    err_o <= wb_live;
                                end else begin
                                    retry_cnt <= retry_cnt + 1'b1;
                                    hbusreq   <= 1'b1;
                                    state     <= StReq;
                                end
`else
                                err_o <= wb_live;
`endif
                            end
                        endcase
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_wb2ahb.sv
// Self-checking bench for wb2ahb: scoreboarded Wishbone cycles against a behavioural AHB slave.
module tb_wb2ahb;
    import ahb_pkg::*;

    localparam int RetryLimit = 2;
`ifdef WB2AHB_RETRY_EN
    localparam int RetryIssues = RetryLimit + 1;
`else
    localparam int RetryIssues = 1;
`endif

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic [15:0] adr_i = '0;
    logic [31:0] dat_i = '0;
    logic [31:0] dat_o;
    logic        we_i = 1'b0;
    logic        cyc_i = 1'b0;
    logic        stb_i = 1'b0;
    logic        ack_o;
    logic        err_o;
    logic        hbusreq;
    logic        hgrant = 1'b0;
    logic [15:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic [31:0] hrdata = 32'hA5A5_5A5A;
    logic        hready = 1'b1;
    logic [1:0]  hresp = HRESP_OKAY;

    always #5 hclk = ~hclk;

    wb2ahb #(
        .AWIDTH     (16),
        .DWIDTH     (32),
        .HSIZE_VAL  (3'b010),
        .RETRY_LIMIT(RetryLimit)
    ) dut (
        .hclk   (hclk),
        .hresetn(hresetn),
        .adr_i  (adr_i),
        .dat_i  (dat_i),
        .dat_o  (dat_o),
        .we_i   (we_i),
        .cyc_i  (cyc_i),
        .stb_i  (stb_i),
        .ack_o  (ack_o),
        .err_o  (err_o),
        .hbusreq(hbusreq),
        .hgrant (hgrant),
        .haddr  (haddr),
        .htrans (htrans),
        .hwrite (hwrite),
        .hsize  (hsize),
        .hburst (hburst),
        .hwdata (hwdata),
        .hrdata (hrdata),
        .hready (hready),
        .hresp  (hresp)
    );

    // kind: 0 = no response, 1 = ack, 2 = err
    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] dat;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rd = 32'h0;

    // One Wishbone cycle with the bench acting as arbiter and AHB slave.
    task automatic run_xfer(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int waits, input int gdelay,
                            input logic [1:0] resp, input int drop_at, input int exp_issues,
                            input int exp_lat, input string name);
        exp_t e;
        exp_t got;
        int   cyc_n = 0;
        int   req_seen = 0;
        int   idle_req = 0;
        int   issues = 0;
        int   fin = 0;
        int   acks = 0;
        int   errs = 0;
        int   lat = -1;
        int   wcnt = 0;
        int   tail = 0;
        bit   in_data = 0;
        bit   err_first = 0;
        bit   done = 0;

        e.kind = (drop_at > 0) ? 2'd0 : (resp == HRESP_OKAY) ? 2'd1 : 2'd2;
        e.dat  = (!we && resp == HRESP_OKAY && drop_at == 0) ? rdata : last_rd;
        last_rd = e.dat;
        exp_q.push_back(e);

        @(negedge hclk);
        cyc_i  = 1'b1;
        stb_i  = 1'b1;
        we_i   = we;
        adr_i  = addr;
        dat_i  = wdata;
        hgrant = (gdelay == 0);
        hready = 1'b1;
        hresp  = HRESP_OKAY;

        while (!done && cyc_n < 300) begin
            @(negedge hclk);
            cyc_n++;
            if (drop_at > 0 && cyc_n == drop_at) begin
                cyc_i = 1'b0;
                stb_i = 1'b0;
            end
            if (ack_o || err_o) begin
                if (ack_o) acks++;
                if (err_o) errs++;
                if (lat < 0) lat = cyc_n;
                cyc_i = 1'b0;
                stb_i = 1'b0;
            end
            if (hbusreq) req_seen++;
            if (req_seen > gdelay) hgrant = 1'b1;
            if (hbusreq && !hgrant) begin
                idle_req++;
                checks++;
                if (htrans !== HTRANS_IDLE) begin
                    errors++;
                    $display("FAIL %s htrans_while_ungranted got %b want %b", name, htrans,
                             HTRANS_IDLE);
                end
            end
            if (in_data) begin
                checks++;
                if (htrans !== HTRANS_IDLE) begin
                    errors++;
                    $display("FAIL %s htrans_data_phase got %b want %b", name, htrans, HTRANS_IDLE);
                end
                if (we) begin
                    checks++;
                    if (hwdata !== wdata) begin
                        errors++;
                        $display("FAIL %s hwdata got %h want %h", name, hwdata, wdata);
                    end
                end
                if (wcnt < waits) begin
                    hready = 1'b0;
                    hresp  = HRESP_OKAY;
                    wcnt++;
                end else if (resp != HRESP_OKAY && !err_first) begin
                    hready    = 1'b0;
                    hresp     = resp;
                    err_first = 1'b1;
                end else begin
                    hready    = 1'b1;
                    hresp     = resp;
                    hrdata    = rdata;
                    in_data   = 1'b0;
                    wcnt      = 0;
                    err_first = 1'b0;
                    fin++;
                end
            end else begin
                hready = 1'b1;
                hresp  = HRESP_OKAY;
                hrdata = 32'hA5A5_5A5A;
                if (fin >= exp_issues) tail++;
                if (tail > 3) done = 1'b1;
            end
            if (htrans === HTRANS_NONSEQ) begin
                issues++;
                in_data = 1'b1;
                checks++;
                if (haddr !== addr || hwrite !== we) begin
                    errors++;
                    $display("FAIL %s addr_phase got haddr=%h hwrite=%b want haddr=%h hwrite=%b",
                             name, haddr, hwrite, addr, we);
                end
            end
        end

        cyc_i  = 1'b0;
        stb_i  = 1'b0;
        hgrant = 1'b0;
        hready = 1'b1;
        hresp  = HRESP_OKAY;

        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout got cycles=%0d want completion within 300", name, cyc_n);
        end
        got = exp_q.pop_front();
        checks++;
        if (acks !== ((got.kind == 2'd1) ? 1 : 0) || errs !== ((got.kind == 2'd2) ? 1 : 0)) begin
            errors++;
            $display("FAIL %s response got acks=%0d errs=%0d want kind=%0d", name, acks, errs,
                     got.kind);
        end
        checks++;
        if (dat_o !== got.dat) begin
            errors++;
            $display("FAIL %s dat_o got %h want %h", name, dat_o, got.dat);
        end
        checks++;
        if (issues !== exp_issues) begin
            errors++;
            $display("FAIL %s nonseq_count got %0d want %0d", name, issues, exp_issues);
        end
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat);
        end
        checks++;
        if (idle_req !== gdelay) begin
            errors++;
            $display("FAIL %s ungranted_cycles got %0d want %0d", name, idle_req, gdelay);
        end
    endtask

    task automatic test_reset();
        hresetn = 1'b0;
        #1;
        checks++;
        if (htrans !== HTRANS_IDLE || haddr !== 16'h0 || hwrite !== 1'b0 || hwdata !== 32'h0 ||
            hbusreq !== 1'b0 || ack_o !== 1'b0 || err_o !== 1'b0 || dat_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got htrans=%b haddr=%h hwrite=%b hwdata=%h req=%b ack=%b err=%b dat_o=%h want all zero",
                     htrans, haddr, hwrite, hwdata, hbusreq, ack_o, err_o, dat_o);
        end
        checks++;
        if (hsize !== 3'b010 || hburst !== 3'b000) begin
            errors++;
            $display("FAIL reset_consts got hsize=%b hburst=%b want 010 000", hsize, hburst);
        end
        repeat (2) @(negedge hclk);
        hresetn = 1'b1;
    endtask

    task automatic test_write();
        run_xfer(1'b1, 16'h0040, 32'hDEADBEEF, 32'h0, 0, 0, HRESP_OKAY, 0, 1, 4, "write");
    endtask

    task automatic test_read_wait();
        run_xfer(1'b0, 16'h0080, 32'h0, 32'h12345678, 2, 0, HRESP_OKAY, 0, 1, 6, "read_wait");
    endtask

    task automatic test_grant_delay();
        run_xfer(1'b0, 16'h00C4, 32'h0, 32'hCAFEF00D, 0, 5, HRESP_OKAY, 0, 1, 9, "grant_delay");
    endtask

    task automatic test_error();
        run_xfer(1'b1, 16'h0100, 32'h0BADC0DE, 32'h0, 0, 0, HRESP_ERROR, 0, 1, 5, "error");
    endtask

    task automatic test_retry();
        run_xfer(1'b0, 16'h0200, 32'h0, 32'h77777777, 0, 0, HRESP_RETRY, 0, RetryIssues,
                 5 + 4 * (RetryIssues - 1), "retry");
        run_xfer(1'b1, 16'h0204, 32'h13579BDF, 32'h0, 0, 0, HRESP_SPLIT, 0, RetryIssues,
                 5 + 4 * (RetryIssues - 1), "split");
    endtask

    task automatic test_cyc_drop();
        run_xfer(1'b0, 16'h0300, 32'h0, 32'hFEEDFACE, 3, 0, HRESP_OKAY, 4, 1, -1, "cyc_drop");
    endtask

    task automatic test_back_to_back();
        run_xfer(1'b1, 16'h0404, 32'h01020304, 32'h0, 0, 0, HRESP_OKAY, 0, 1, 4, "b2b_write");
        run_xfer(1'b0, 16'h0408, 32'h0, 32'h55AA00FF, 1, 0, HRESP_OKAY, 0, 1, 5, "b2b_read");
    endtask

    task automatic test_reset_mid();
        @(negedge hclk);
        cyc_i  = 1'b1;
        stb_i  = 1'b1;
        we_i   = 1'b0;
        adr_i  = 16'h0ABC;
        hgrant = 1'b1;
        repeat (3) @(negedge hclk);
        hready = 1'b0;
        @(negedge hclk);
        checks++;
        if (htrans !== HTRANS_IDLE || haddr !== 16'h0ABC) begin
            errors++;
            $display("FAIL reset_mid_setup got htrans=%b haddr=%h want 00 0abc", htrans, haddr);
        end
        #2;
        hresetn = 1'b0;
        #1;
        checks++;
        if (htrans !== HTRANS_IDLE || haddr !== 16'h0 || hwrite !== 1'b0 || hwdata !== 32'h0 ||
            hbusreq !== 1'b0 || ack_o !== 1'b0 || err_o !== 1'b0 || dat_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid got htrans=%b haddr=%h hwrite=%b hwdata=%h req=%b ack=%b err=%b dat_o=%h want all zero",
                     htrans, haddr, hwrite, hwdata, hbusreq, ack_o, err_o, dat_o);
        end
        last_rd = 32'h0;
        @(negedge hclk);
        cyc_i   = 1'b0;
        stb_i   = 1'b0;
        hgrant  = 1'b0;
        hready  = 1'b1;
        @(negedge hclk);
        hresetn = 1'b1;
        run_xfer(1'b0, 16'h0ACC, 32'h0, 32'h89ABCDEF, 0, 0, HRESP_OKAY, 0, 1, 4, "after_reset");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_grant_delay();
        test_error();
        test_retry();
        test_cyc_drop();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got time limit want completion");
        $fatal(1, "watchdog");
    end

endmodule
